// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited I-cache
// requests, queues in-order responses for decode and handles back-end redirects.
module cpu_fetch #(
    parameter int              ADDR     = 32,
    parameter int              INST     = 32,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_,
    output logic            ic_req,
    output logic [ADDR-1:0] ic_addr,
    input  logic            ic_ready,
    input  logic            ic_resp,
    input  logic [INST-1:0] ic_inst,
    input  logic            ic_err,
    input  logic            redirect,
    input  logic [ADDR-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [ADDR-1:0] dec_pc,
    output logic [INST-1:0] dec_inst,
    output logic            dec_fault,
    input  logic            dec_ready
);

    localparam int              PW         = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int              CW         = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FQ_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [ADDR-1:0] PC_STEP    = ADDR'(4);
    localparam logic [ADDR-1:0] RESET_PC_W = {RESET_PC[ADDR-1:2], 2'b00};

    // Architectural state
    logic [ADDR-1:0] pc_reg,      pc_next;
    logic            halt_reg,    halt_next;
    logic [CW-1:0]   outst_reg,   outst_next;
    logic [CW-1:0]   drop_reg,    drop_next;
    logic [CW-1:0]   count_reg,   count_next;
    logic [PW-1:0]   head_reg,    head_next;
    logic [PW-1:0]   tail_reg,    tail_next;
    logic [PW-1:0]   pf_head_reg, pf_head_next;
    logic [PW-1:0]   pf_tail_reg, pf_tail_next;

    // Storage: fetch queue entries and the PC tags of requests still in flight
    logic [ADDR-1:0] q_pc    [FQ_DEPTH];
    logic [INST-1:0] q_inst  [FQ_DEPTH];
    logic            q_fault [FQ_DEPTH];
    logic [ADDR-1:0] pf_pc   [FQ_DEPTH];

    logic            issue;
    logic            take;
    logic            deq;
    logic [CW:0]     credit_used;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Buffered entries plus in-flight requests (stale ones included) may never
    // exceed the queue size, so every response always has room to land.
    assign credit_used = {1'b0, count_reg} + {1'b0, outst_reg};
    assign ic_req      = reset_ && !halt_reg && !redirect && (credit_used < {1'b0, DEPTH_C});
    assign ic_addr     = pc_reg;

    assign issue = ic_req && ic_ready;
    assign take  = ic_resp && !redirect && (drop_reg == '0);
    assign deq   = dec_valid && dec_ready;

    assign dec_valid = (count_reg != '0);
    assign dec_pc    = dec_valid ? q_pc[head_reg]    : '0;
    assign dec_inst  = dec_valid ? q_inst[head_reg]  : '0;
    assign dec_fault = dec_valid ? q_fault[head_reg] : 1'b0;

    always_comb begin
        pc_next      = pc_reg;
        halt_next    = halt_reg;
        outst_next   = outst_reg;
        drop_next    = drop_reg;
        count_next   = count_reg;
        head_next    = head_reg;
        tail_next    = tail_reg;
        pf_head_next = pf_head_reg;
        pf_tail_next = pf_tail_reg;

        unique case ({issue, ic_resp})
            2'b10:   outst_next = outst_reg + CNT_ONE;
            2'b01:   outst_next = outst_reg - CNT_ONE;
            default: outst_next = outst_reg;
        endcase

        if (redirect) begin
            // Everything not yet returned becomes stale; this cycle's response is
            // discarded outright, so it is not counted.
            pc_next      = {redirect_pc[ADDR-1:2], 2'b00};
            halt_next    = 1'b0;
            drop_next    = outst_reg - CW'(ic_resp);
            count_next   = '0;
            head_next    = '0;
            tail_next    = '0;
            pf_head_next = '0;
            pf_tail_next = '0;
        end else begin
            if (issue) begin
                pc_next      = pc_reg + PC_STEP;
                pf_tail_next = pf_tail_reg + PTR_ONE;
            end
            if (ic_resp && (drop_reg != '0)) begin
                drop_next = drop_reg - CNT_ONE;
            end
            if (take) begin
                tail_next    = tail_reg + PTR_ONE;
                pf_head_next = pf_head_reg + PTR_ONE;
                if (ic_err) begin
                    halt_next = 1'b1;
                end
            end
            if (deq) begin
                head_next = head_reg + PTR_ONE;
            end
            unique case ({take, deq})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc_reg      <= RESET_PC_W;
            halt_reg    <= 1'b0;
            outst_reg   <= '0;
            drop_reg    <= '0;
            count_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            pf_head_reg <= '0;
            pf_tail_reg <= '0;
        end else begin
            pc_reg      <= pc_next;
            halt_reg    <= halt_next;
            outst_reg   <= outst_next;
            drop_reg    <= drop_next;
            count_reg   <= count_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            pf_head_reg <= pf_head_next;
            pf_tail_reg <= pf_tail_next;
        end
    end

    // Data storage needs no reset: occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (issue) begin
            pf_pc[pf_tail_reg] <= pc_reg;
        end
        if (take) begin
            q_pc[tail_reg]    <= pf_pc[pf_head_reg];
            q_inst[tail_reg]  <= ic_inst;
            q_fault[tail_reg] <= ic_err;
        end
    end

    resp_without_request: assert property (@(posedge clk) disable iff (!reset_)
        ic_resp |-> (outst_reg != '0));

    queue_overflow: assert property (@(posedge clk) disable iff (!reset_)
        take |-> (count_reg != DEPTH_C));

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: an in-order I-cache model with programmable
// latency, request/decode logs with cycle stamps, and one task per scenario.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready = 1'b1;
    logic        ic_resp = 1'b0;
    logic [31:0] ic_inst = '0;
    logic        ic_err = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_fault;
    logic        dec_ready = 1'b1;

    typedef struct {logic [31:0] addr; int due;} pend_t;
    typedef struct {logic [31:0] addr; int cyc;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] inst; logic fault; int cyc;} dec_t;

    pend_t       pend[$];
    req_t        req_log[$];
    dec_t        dec_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] err_addr = 32'hFFFF_FFF1;

    cpu_fetch #(
        .ADDR(32), .INST(32), .RESET_PC(32'h0000_0100), .FQ_DEPTH(4)
    ) dut (
        .clk(clk), .reset_(reset_),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready),
        .ic_resp(ic_resp), .ic_inst(ic_inst), .ic_err(ic_err),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
        .dec_fault(dec_fault), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i].addr : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] dpc_at(input int i);
        return (i < dec_log.size()) ? dec_log[i].pc : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] dinst_at(input int i);
        return (i < dec_log.size()) ? dec_log[i].inst : 32'hFFFF_FFFF;
    endfunction
    function automatic logic dfault_at(input int i);
        return (i < dec_log.size()) ? dec_log[i].fault : 1'bx;
    endfunction
    function automatic int dcyc_at(input int i);
        return (i < dec_log.size()) ? dec_log[i].cyc : -1000;
    endfunction

    // Cache drives its response just after the falling edge; everything is
    // sampled one time unit before the rising edge.
    always begin
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ic_resp = 1'b1;
            ic_inst = inst_of(pend[0].addr);
            ic_err  = (pend[0].addr == err_addr);
        end else begin
            ic_resp = 1'b0;
            ic_inst = '0;
            ic_err  = 1'b0;
        end
        #4;
        if (!reset_) begin
            pend.delete();
        end else begin
            if (ic_resp) void'(pend.pop_front());
            if (ic_req && ic_ready) begin
                pend.push_back('{ic_addr, cyc + lat});
                req_log.push_back('{ic_addr, cyc});
            end
            if (dec_valid && dec_ready) begin
                dec_log.push_back('{dec_pc, dec_inst, dec_fault, cyc});
                $display("[%0d] decode pc=%h inst=%h fault=%0b", cyc, dec_pc, dec_inst, dec_fault);
            end
        end
        cyc++;
    end

    task automatic do_redirect(input logic [31:0] a);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = a;
        ic_ready    = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        req_log.delete();
        dec_log.delete();
    endtask

    task automatic quiesce();
        ic_ready = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL reset_ic_req: got %b expected 0", ic_req); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc: got %h expected 0", dec_pc); end
        checks++; if (dec_inst !== 32'h0) begin errors++; $display("FAIL reset_dec_inst: got %h expected 0", dec_inst); end
        checks++; if (dec_fault !== 1'b0) begin errors++; $display("FAIL reset_dec_fault: got %b expected 0", dec_fault); end
        @(negedge clk);
        reset_ = 1'b1;
        #1;
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL release_ic_req: got %b expected 1", ic_req); end
        checks++; if (ic_addr !== 32'h100) begin errors++; $display("FAIL release_ic_addr: got %h expected 00000100", ic_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            e = 32'h100 + 32'(4 * i);
            checks++; if (req_at(i) !== e) begin errors++; $display("FAIL stream_req[%0d]: got %h expected %h", i, req_at(i), e); end
            checks++; if (dpc_at(i) !== e) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, dpc_at(i), e); end
            checks++; if (dinst_at(i) !== inst_of(e)) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, dinst_at(i), inst_of(e)); end
            checks++; if (dcyc_at(i) - dcyc_at(0) !== i) begin errors++; $display("FAIL stream_rate[%0d]: got %0d expected %0d", i, dcyc_at(i) - dcyc_at(0), i); end
        end
        checks++;
        if (req_log.size() == 0 || dcyc_at(0) - req_log[0].cyc != 2) begin
            errors++; $display("FAIL stream_latency: got %0d expected 2", dcyc_at(0) - ((req_log.size() > 0) ? req_log[0].cyc : 0));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        dec_ready = 1'b0;
        do_redirect(32'h1000);
        repeat (9) @(negedge clk);
        #1;
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
        for (int i = 0; i < 4; i++) begin
            e = 32'h1000 + 32'(4 * i);
            checks++; if (req_at(i) !== e) begin errors++; $display("FAIL bp_req[%0d]: got %h expected %h", i, req_at(i), e); end
        end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL bp_ic_req_full: got %b expected 0", ic_req); end
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_dec_valid: got %b expected 1", dec_valid); end
        checks++; if (dec_pc !== 32'h1000) begin errors++; $display("FAIL bp_head_pc: got %h expected 00001000", dec_pc); end
        dec_ready = 1'b1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            e = 32'h1000 + 32'(4 * i);
            checks++; if (dpc_at(i) !== e) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, dpc_at(i), e); end
            checks++; if (dinst_at(i) !== inst_of(e)) begin errors++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, dinst_at(i), inst_of(e)); end
            checks++; if (dcyc_at(i) - dcyc_at(0) !== i) begin errors++; $display("FAIL bp_rate[%0d]: got %0d expected %0d", i, dcyc_at(i) - dcyc_at(0), i); end
        end
    endtask

    task automatic test_redirect_flush();
        logic [31:0] e;
        quiesce();
        lat = 3;
        do_redirect(32'h3000);
        repeat (8) @(negedge clk);
        do_redirect(32'h2000);
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_dec_valid: got %b expected 0", dec_valid); end
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL flush_ic_req: got %b expected 1", ic_req); end
        checks++; if (ic_addr !== 32'h2000) begin errors++; $display("FAIL flush_ic_addr: got %h expected 00002000", ic_addr); end
        repeat (15) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            e = 32'h2000 + 32'(4 * i);
            checks++; if (dpc_at(i) !== e) begin errors++; $display("FAIL flush_pc[%0d]: got %h expected %h", i, dpc_at(i), e); end
            checks++; if (dinst_at(i) !== inst_of(e)) begin errors++; $display("FAIL flush_inst[%0d]: got %h expected %h", i, dinst_at(i), inst_of(e)); end
        end
    endtask

    task automatic test_redirect_collision();
        logic [31:0] e;
        quiesce();
        lat = 1;
        do_redirect(32'h5000);
        repeat (7) @(negedge clk);
        #1;
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL coll_dec_valid: got %b expected 1", dec_valid); end
        checks++; if (dec_pc !== 32'h5014) begin errors++; $display("FAIL coll_head_pc: got %h expected 00005014", dec_pc); end
        redirect    = 1'b1;
        redirect_pc = 32'h6000;
        @(negedge clk);
        redirect = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            e = (i < 6) ? 32'h5000 + 32'(4 * i) : 32'h6000 + 32'(4 * (i - 6));
            checks++; if (dpc_at(i) !== e) begin errors++; $display("FAIL coll_pc[%0d]: got %h expected %h", i, dpc_at(i), e); end
            checks++; if (dinst_at(i) !== inst_of(e)) begin errors++; $display("FAIL coll_inst[%0d]: got %h expected %h", i, dinst_at(i), inst_of(e)); end
        end
    endtask

    task automatic test_fault();
        logic [31:0] e;
        quiesce();
        lat = 1;
        err_addr = 32'h108;
        do_redirect(32'h100);
        repeat (9) @(negedge clk);
        #1;
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL fault_req_count: got %0d expected 4", req_log.size()); end
        checks++; if (dec_log.size() != 4) begin errors++; $display("FAIL fault_dec_count: got %0d expected 4", dec_log.size()); end
        for (int i = 0; i < 4; i++) begin
            e = 32'h100 + 32'(4 * i);
            checks++; if (dpc_at(i) !== e) begin errors++; $display("FAIL fault_pc[%0d]: got %h expected %h", i, dpc_at(i), e); end
            checks++; if (dfault_at(i) !== (i == 2)) begin errors++; $display("FAIL fault_flag[%0d]: got %b expected %b", i, dfault_at(i), (i == 2)); end
        end
        checks++; if (dinst_at(2) !== inst_of(32'h108)) begin errors++; $display("FAIL fault_inst: got %h expected %h", dinst_at(2), inst_of(32'h108)); end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL fault_halt: got %b expected 0", ic_req); end
        err_addr = 32'hFFFF_FFF1;
        do_redirect(32'h400);
        repeat (5) @(negedge clk);
        #1;
        checks++; if (req_at(0) !== 32'h400) begin errors++; $display("FAIL resume_req: got %h expected 00000400", req_at(0)); end
        checks++; if (dpc_at(0) !== 32'h400) begin errors++; $display("FAIL resume_pc: got %h expected 00000400", dpc_at(0)); end
        checks++; if (dfault_at(0) !== 1'b0) begin errors++; $display("FAIL resume_fault: got %b expected 0", dfault_at(0)); end
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL resume_ic_req: got %b expected 1", ic_req); end
    endtask

    task automatic test_wrap();
        do_redirect(32'hFFFF_FFFF);
        #1;
        checks++; if (ic_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h expected fffffffc", ic_addr); end
        repeat (5) @(negedge clk);
        checks++; if (req_at(1) !== 32'h0) begin errors++; $display("FAIL wrap_req: got %h expected 00000000", req_at(1)); end
        checks++; if (dpc_at(0) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", dpc_at(0)); end
        checks++; if (dpc_at(1) !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 00000000", dpc_at(1)); end
        checks++; if (dinst_at(1) !== inst_of(32'h0)) begin errors++; $display("FAIL wrap_inst: got %h expected %h", dinst_at(1), inst_of(32'h0)); end
    endtask

    task automatic test_ready_stall();
        do_redirect(32'h7000);
        ic_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 1", i, ic_req); end
            checks++; if (ic_addr !== 32'h7000) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 00007000", i, ic_addr); end
        end
        ic_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (req_at(0) !== 32'h7000) begin errors++; $display("FAIL stall_req0: got %h expected 00007000", req_at(0)); end
        checks++; if (req_at(1) !== 32'h7004) begin errors++; $display("FAIL stall_req1: got %h expected 00007004", req_at(1)); end
        checks++; if (dpc_at(0) !== 32'h7000) begin errors++; $display("FAIL stall_pc0: got %h expected 00007000", dpc_at(0)); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL areset_ic_req: got %b expected 0", ic_req); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL areset_dec_valid: got %b expected 0", dec_valid); end
        checks++; if (ic_addr !== 32'h100) begin errors++; $display("FAIL areset_pc: got %h expected 00000100", ic_addr); end
        @(negedge clk);
        reset_ = 1'b1;
        req_log.delete();
        dec_log.delete();
        repeat (5) @(negedge clk);
        checks++; if (req_at(0) !== 32'h100) begin errors++; $display("FAIL areset_req0: got %h expected 00000100", req_at(0)); end
        checks++; if (dpc_at(0) !== 32'h100) begin errors++; $display("FAIL areset_dec0: got %h expected 00000100", dpc_at(0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collision();
        test_fault();
        test_wrap();
        test_ready_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
